// File: rtl/pio_mailbox_arbiter.sv
// Round-robin arbiter sharing one 32-bit ARM<->FPGA PIO mailbox pair among NUM_REQ requesters.
// The ARM polls for a grant, then reads the granted requester's payload captured at grant time.
module pio_mailbox_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [31:0]           inputPio,
  output logic [31:0]           outputPio,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  led
);

  localparam logic [31:0] CMD_POLL = 32'h0000_0001;
  localparam logic [31:0] CMD_READ = 32'h0000_0201;

  localparam logic [7:0] CODE_EMPTY = 8'h01;
  localparam logic [7:0] CODE_GRANT = 8'h02;
  localparam logic [7:0] CODE_DATA  = 8'h03;
  localparam logic [7:0] CODE_ERROR = 8'h04;

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_GRANTED} state_t;

  state_t               state_q, state_d;
  logic [31:0]          in_q, in_d;
  logic [31:0]          in_q2, in2_d;
  logic [31:0]          out_q, out_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [3:0]           rr_q, rr_d;
  logic [3:0]           id_q, id_d;
  logic [15:0]          data_q, data_d;
  logic [TW-1:0]        tmo_q, tmo_d;

  logic                 is_poll, is_read;
  logic                 found;
  logic [3:0]           win_id;
  logic [15:0]          win_data;
  logic [NUM_REQ-1:0]   id_onehot;
  logic [3:0]           nxt_ptr;
  logic [TW-1:0]        tmo_inc;
  logic                 expire;

  // A command only counts on the edge where the double-registered word changes to a valid value.
  assign is_poll = (in_q != in_q2) && (in_q == CMD_POLL);
  assign is_read = (in_q != in_q2) && (in_q == CMD_READ);

  assign nxt_ptr = (id_q == 4'(NUM_REQ - 1)) ? 4'h0 : id_q + 4'h1;
  assign tmo_inc = tmo_q + TW'(1);
  assign expire  = (tmo_inc == TW'(TIMEOUT));

  // Two passes give a rotating priority: indices at/above rr_q first, then the wrapped-around ones.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    found    = 1'b0;
    win_id   = 4'h0;
    win_data = 16'h0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (4'(i) >= rr_q)) begin
        found    = 1'b1;
        win_id   = 4'(i);
        win_data = req_data[16*i +: 16];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (4'(i) < rr_q)) begin
        found    = 1'b1;
        win_id   = 4'(i);
        win_data = req_data[16*i +: 16];
      end
    end
  end

  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      id_onehot[i] = (id_q == 4'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    in_d    = inputPio;
    in2_d   = in_q;
    out_d   = out_q;
    ack_d   = '0;
    rr_d    = rr_q;
    id_d    = id_q;
    data_d  = data_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      S_IDLE: begin
        if (is_poll) begin
          if (found) begin
            id_d    = win_id;
            data_d  = win_data;
            out_d   = {4'h0, win_id, CODE_GRANT, 16'h0000};
            tmo_d   = '0;
            state_d = S_GRANTED;
          end else begin
            out_d = {4'h0, 4'h0, CODE_EMPTY, 16'h0000};
          end
        end else if (is_read) begin
          out_d = {4'h0, 4'hF, CODE_ERROR, 16'h0000};
        end
      end
      S_GRANTED: begin
        tmo_d = tmo_inc;
        // A READ landing on the expiry edge still delivers.
        if (is_read) begin
          out_d   = {4'h0, id_q, CODE_DATA, data_q};
          ack_d   = id_onehot;
          rr_d    = nxt_ptr;
          state_d = S_IDLE;
        end else if (expire) begin
          out_d   = {4'h0, id_q, CODE_ERROR, 16'h0000};
          rr_d    = nxt_ptr;
          state_d = S_IDLE;
        end else if (is_poll) begin
          out_d = {4'h0, id_q, CODE_GRANT, 16'h0000};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      in_q    <= '0;
      in_q2   <= '0;
      out_q   <= '0;
      ack_q   <= '0;
      rr_q    <= '0;
      id_q    <= '0;
      data_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      in_q2   <= in2_d;
      out_q   <= out_d;
      ack_q   <= ack_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
    end
  end

  assign outputPio = out_q;
  assign ack       = ack_q;
  assign led       = (state_q == S_GRANTED);

endmodule

// File: tb/tb_pio_mailbox_arbiter.sv
// Directed-vector bench for pio_mailbox_arbiter (NUM_REQ=4, TIMEOUT=16).
// Each task drives one scenario and compares against hand-computed words.
module tb_pio_mailbox_arbiter;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] inputPio = 32'h0;
  logic [31:0] outputPio;
  logic [3:0]  req = 4'h0;
  logic [63:0] req_data = 64'h0;
  logic [3:0]  ack;
  logic        led;

  int vectors = 0;
  int miscompares = 0;

  pio_mailbox_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .inputPio (inputPio),
    .outputPio(outputPio),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .led      (led)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0t need < 200000", $time);
    $fatal(1, "watchdog");
  end

  // Write a word, then land 1 time unit after the edge that would accept it.
  task automatic send(input logic [31:0] cmd);
    @(negedge clock);
    inputPio = cmd;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    resetn   = 1'b0;
    inputPio = 32'h0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    req    = 4'h0;
    send(32'h1);
    vectors++;
    if (outputPio !== 32'h0001_0000) begin
      miscompares++; $display("FAIL reset_pre_poll: got %h need %h", outputPio, 32'h0001_0000);
    end
    send(32'h0);
    @(posedge clock);
    #3 resetn = 1'b0;
    #1;
    vectors++;
    if (outputPio !== 32'h0 || ack !== 4'h0 || led !== 1'b0) begin
      miscompares++; $display("FAIL reset_async: got out=%h ack=%b led=%b need 0/0/0", outputPio, ack, led);
    end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_empty_poll();
    req = 4'h0;
    send(32'h1);
    vectors++;
    if (outputPio !== 32'h0001_0000 || led !== 1'b0) begin
      miscompares++; $display("FAIL empty_poll: got out=%h led=%b need 00010000/0", outputPio, led);
    end
    send(32'h0);
  endtask

  task automatic test_single_delivery();
    req      = 4'b0100;
    req_data = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
    send(32'h1);
    vectors++;
    if (outputPio !== 32'h0202_0000 || led !== 1'b1) begin
      miscompares++; $display("FAIL single_grant: got out=%h led=%b need 02020000/1", outputPio, led);
    end
    req_data[47:32] = 16'h1234;
    req             = 4'b0000;
    send(32'h0);
    send(32'h201);
    vectors++;
    if (outputPio !== 32'h0203_BEEF || ack !== 4'b0100 || led !== 1'b0) begin
      miscompares++; $display("FAIL single_data: got out=%h ack=%b led=%b need 0203beef/0100/0", outputPio, ack, led);
    end
    @(posedge clock); #1;
    vectors++;
    if (ack !== 4'b0000 || outputPio !== 32'h0203_BEEF) begin
      miscompares++; $display("FAIL single_ack_pulse: got ack=%b out=%h need 0000/0203beef", ack, outputPio);
    end
    send(32'h0);
  endtask

  task automatic test_protocol_errors();
    send(32'h201);
    vectors++;
    if (outputPio !== 32'h0F04_0000 || ack !== 4'h0) begin
      miscompares++; $display("FAIL read_in_idle: got out=%h ack=%b need 0f040000/0000", outputPio, ack);
    end
    req = 4'b0001;
    send(32'h5);
    repeat (3) @(posedge clock); #1;
    vectors++;
    if (outputPio !== 32'h0F04_0000 || led !== 1'b0) begin
      miscompares++; $display("FAIL invalid_word: got out=%h led=%b need 0f040000/0", outputPio, led);
    end
    req = 4'b0000;
    send(32'h0);
    send(32'h1);
    req = 4'b0001;
    repeat (4) @(posedge clock); #1;
    vectors++;
    if (outputPio !== 32'h0001_0000 || led !== 1'b0) begin
      miscompares++; $display("FAIL repeated_poll: got out=%h led=%b need 00010000/0", outputPio, led);
    end
    send(32'h0);
    send(32'h1);
    vectors++;
    if (outputPio !== 32'h0002_0000 || led !== 1'b1) begin
      miscompares++; $display("FAIL wrap_grant: got out=%h led=%b need 00020000/1", outputPio, led);
    end
    req = 4'b0110;
    send(32'h0);
    send(32'h1);
    vectors++;
    if (outputPio !== 32'h0002_0000 || led !== 1'b1) begin
      miscompares++; $display("FAIL poll_while_granted: got out=%h led=%b need 00020000/1", outputPio, led);
    end
    send(32'h0);
    send(32'h201);
    vectors++;
    if (outputPio !== 32'h0003_1111 || ack !== 4'b0001) begin
      miscompares++; $display("FAIL granted_read: got out=%h ack=%b need 00031111/0001", outputPio, ack);
    end
    send(32'h0);
  endtask

  task automatic test_round_robin();
    logic [3:0] order [6];
    order = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd3};
    apply_reset();
    req_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    req      = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      if (n == 5) req = 4'b1001;
      send(32'h1);
      vectors++;
      if (outputPio !== {4'h0, order[n], 8'h02, 16'h0000}) begin
        miscompares++; $display("FAIL rr_grant_%0d: got %h need id %0d", n, outputPio, order[n]);
      end
      send(32'h0);
      send(32'h201);
      vectors++;
      if (outputPio !== {4'h0, order[n], 8'h03, 16'hA000 | 16'(order[n])} || ack !== (4'b0001 << order[n])) begin
        miscompares++; $display("FAIL rr_data_%0d: got out=%h ack=%b need id %0d", n, outputPio, ack, order[n]);
      end
      send(32'h0);
    end
  endtask

  task automatic test_timeout();
    req = 4'b0010;
    send(32'h1);
    vectors++;
    if (outputPio !== 32'h0102_0000) begin
      miscompares++; $display("FAIL tmo_grant: got %h need 01020000", outputPio);
    end
    for (int c = 1; c <= 15; c++) begin
      @(posedge clock); #1;
      vectors++;
      if (outputPio !== 32'h0102_0000 || ack !== 4'h0 || led !== 1'b1) begin
        miscompares++; $display("FAIL tmo_hold_%0d: got out=%h ack=%b led=%b need 01020000/0000/1", c, outputPio, ack, led);
      end
    end
    @(posedge clock); #1;
    vectors++;
    if (outputPio !== 32'h0104_0000 || ack !== 4'h0 || led !== 1'b0) begin
      miscompares++; $display("FAIL tmo_expire: got out=%h ack=%b led=%b need 01040000/0000/0", outputPio, ack, led);
    end
    req = 4'b0011;
    send(32'h0);
    send(32'h1);
    vectors++;
    if (outputPio !== 32'h0002_0000) begin
      miscompares++; $display("FAIL tmo_next_grant: got %h need 00020000", outputPio);
    end
    send(32'h0);
    send(32'h201);
    vectors++;
    if (outputPio !== 32'h0003_A000 || ack !== 4'b0001) begin
      miscompares++; $display("FAIL tmo_next_data: got out=%h ack=%b need 0003a000/0001", outputPio, ack);
    end
    send(32'h0);
  endtask

  task automatic test_read_at_expiry();
    req = 4'b0100;
    send(32'h1);
    vectors++;
    if (outputPio !== 32'h0202_0000) begin
      miscompares++; $display("FAIL expiry_grant: got %h need 02020000", outputPio);
    end
    repeat (14) @(posedge clock);
    @(negedge clock);
    inputPio = 32'h201;
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if (outputPio !== 32'h0203_A002 || ack !== 4'b0100) begin
      miscompares++; $display("FAIL read_at_expiry: got out=%h ack=%b need 0203a002/0100", outputPio, ack);
    end
    send(32'h0);
  endtask

  task automatic test_reset_mid_grant();
    req = 4'b0001;
    send(32'h1);
    vectors++;
    if (outputPio !== 32'h0002_0000 || led !== 1'b1) begin
      miscompares++; $display("FAIL midgrant_grant: got out=%h led=%b need 00020000/1", outputPio, led);
    end
    @(posedge clock);
    #3 resetn = 1'b0;
    inputPio = 32'h0;
    #1;
    vectors++;
    if (outputPio !== 32'h0 || ack !== 4'h0 || led !== 1'b0) begin
      miscompares++; $display("FAIL midgrant_reset: got out=%h ack=%b led=%b need 0/0/0", outputPio, ack, led);
    end
    @(negedge clock);
    resetn = 1'b1;
    send(32'h201);
    vectors++;
    if (outputPio !== 32'h0F04_0000 || ack !== 4'h0) begin
      miscompares++; $display("FAIL midgrant_read: got out=%h ack=%b need 0f040000/0000", outputPio, ack);
    end
  endtask

  initial begin
    test_reset();
    test_empty_poll();
    test_single_delivery();
    test_protocol_errors();
    test_round_robin();
    test_timeout();
    test_read_at_expiry();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pio_mailbox_arbiter.md
Name: pio_mailbox_arbiter

Overview:
- Shares the single 32-bit ARM<->FPGA PIO mailbox pair (inputPio from the ARM, outputPio to the ARM) between NUM_REQ FPGA-side requesters.
- The ARM polls over inputPio. The block picks a requester by round-robin, reports the grant, then delivers that requester's 16-bit payload on a read command.
- Sits between the HPS PIO bridge and the internal message producers. It replaces single-producer, hard-wired mailbox handling.

Parameters:
- NUM_REQ, 4, number of requesters. Legal range 1..15; id 0xF is reserved.
- TIMEOUT, 1024, cycles allowed in GRANTED without a READ before the grant is revoked. Must be ≥ 1.

Ports:
- clock  input  1  system clock, rising-edge active
- resetn  input  1  asynchronous, active-low reset
- inputPio  input  32  ARM command word, synchronous to clock
- outputPio  output  32  registered response word to the ARM
- req  input  NUM_REQ  per-requester pending flag, level
- req_data  input  16*NUM_REQ  payloads; requester i uses bits [16i+15:16i]
- ack  output  NUM_REQ  one-cycle pulse: payload of requester i delivered
- led  output  1  high while a grant is held (GRANTED state)

Behaviour:
- Reset (resetn=0, async): outputPio=0x00000000, ack=0, led=0, state=IDLE, rr_ptr=0, timeout counter=0, input history registers=0.
- Command decode:
  - inputPio is registered twice (in_q, in_q2).
  - A command is accepted on the rising edge where in_q != in_q2 and in_q is a valid command.
  - Valid commands: POLL=0x00000001, READ=0x00000201.
  - Any other value, including 0x00000000, is never a command. The ARM writes 0 between commands.
  - Repeating the same command without an intervening change is ignored.
- Response format: outputPio = {4'h0, id[3:0], code[7:0], data[15:0]}.
  - Codes: 0x01 EMPTY, 0x02 GRANT, 0x03 DATA, 0x04 ERROR.
- Latency: outputPio updates on the edge that accepts the command, i.e. the 2nd rising edge after inputPio changes. outputPio holds its value until the next response.
- FSM state IDLE:
  - POLL with req != 0: winner = first set req bit searching from rr_ptr upward, modulo NUM_REQ. Latch winner id and req_data[winner]. outputPio = {id, 0x02, 0x0000}. Clear the timeout counter. Go to GRANTED.
  - POLL with req == 0: outputPio = 0x00010000. Stay in IDLE.
  - READ: outputPio = 0x0F040000. Stay in IDLE.
- FSM state GRANTED:
  - READ: outputPio = {id, 0x03, latched data}. Pulse ack[id] for exactly one cycle, registered on the same edge. rr_ptr = (id+1) mod NUM_REQ. Go to IDLE.
  - POLL: re-issue {id, 0x02, 0x0000}. Idempotent: no new arbitration, and the timeout counter is not cleared.
  - Timeout counter increments every cycle. On the cycle it reaches TIMEOUT with no READ accepted: outputPio = {id, 0x04, 0x0000}, no ack, rr_ptr = (id+1) mod NUM_REQ, go to IDLE.
  - READ accepted on the same edge as expiry: READ wins and is delivered normally.
- Payload handling:
  - Payload is captured at grant time. Later changes to req or req_data of the winner do not affect the delivered data.
  - The winner dropping req while granted still results in delivery and an ack.
  - Requesters must hold req high until ack. Deasserting req the cycle after ack is the requester's duty; arbitration only samples req at POLL.
- Outputs:
  - ack is at most one-hot, and is 0 in all cycles except the delivery edge.
  - led = (state == GRANTED), registered.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Reset asserted mid-grant: immediate return to reset values. No ack is emitted, and the latched payload is discarded.

Test Plan:
- Reset check: assert resetn=0 asynchronously mid-cycle → outputPio=0x00000000, ack=0, led=0 immediately.
- Empty poll: req=0; inputPio=0x1 → outputPio=0x00010000 two edges later; led stays 0.
- Single delivery, with req=4'b0100 and req_data[2]=0xBEEF:
  - POLL → outputPio=0x02020000, led=1.
  - Write 0, then READ 0x201 → outputPio=0x0203BEEF, ack=4'b0100 for one cycle, led=0.
  - Change req_data after the grant to 0x1234 → delivered data is still 0xBEEF.
- Round-robin: req=4'b1111 held; five POLL/READ pairs → granted ids 0,1,2,3,0. Then req=4'b1001 from rr_ptr=1 → next grant id 3.
- Timeout, with TIMEOUT=16: POLL grants id 1 and no READ follows → exactly 16 cycles later outputPio=0x01040000, ack never pulses, next POLL with req=4'b0011 grants id 0.
- Protocol errors:
  - READ in IDLE → 0x0F040000.
  - Repeated POLL without an intervening 0 → no change.
  - inputPio=0x00000005 → ignored.
  - POLL while GRANTED → same GRANT word, no re-arbitration.
